acorn128_job_sched: RTL and testbench
=====================================

Name: acorn128_job_sched

Overview:
- Round-robin scheduler that shares one acorn128_top core between two requesters.
- Accepts one job at a time and latches its key, IV, data, AD, length and expected tag.
- Sequences the core's active-high reset and start_in, then waits for ready_out under a timeout.
- Returns the result, tag, tag-compare verdict and timeout flag on a valid/ready response channel.

Parameters:
- RST_CYCLES, 2, cycles the core is held in reset before start (min 1).
- TIMEOUT_CYCLES, 4096, maximum RUN cycles before the job is aborted.
- CNT_W, 13, counter width; must hold max(RST_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester job valid (bit i = requester i)
- req_ready  out  2  one-hot accept pulse
- req_encrypt  in  2  1=encrypt, 0=decrypt
- req_key  in  256  {req1,req0} 128b keys
- req_iv  in  256  IVs
- req_data  in  256  plaintext (enc) or ciphertext (dec)
- req_ad  in  256  associated data
- req_len  in  128  {req1,req0} 64b data lengths
- req_tag  in  256  expected tag (decrypt only)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  requester index of this response
- rsp_data  out  128  ciphertext (enc) or plaintext (dec)
- rsp_tag  out  128  core tag
- rsp_tag_ok  out  1  dec: core tag == expected tag; enc: 1
- rsp_timeout  out  1  job aborted by timeout
- busy  out  1  state != IDLE
- core_rst  out  1  active-high reset to the core
- core_start  out  1  core start_in
- core_encrypt  out  1  core encrypt_in
- core_key, core_iv, core_plaintext, core_ciphertext, core_ad  out  128 each  latched job fields; core_plaintext and core_ciphertext both carry req_data
- core_len  out  64  latched length
- core_result  in  128  core ciphertext_out; carries the result in both modes
- core_tag  in  128  core tag_out
- core_ready  in  1  core ready_out

Behaviour:
- Reset (rst=0, asynchronous, may occur mid-job):
  - State goes to IDLE; rr_ptr=1, so req0 wins first; all counters clear.
  - req_ready=0, rsp_*=0, busy=0, core_start=0, core_rst=1, all core data outputs=0.
  - Any in-flight job is dropped with no response.
- States: IDLE, CRST, RUN, RESP.
- IDLE:
  - core_rst=1, core_start=0.
  - Grant: if exactly one req_valid is set, grant it; if both are set, grant the index != rr_ptr.
  - The grant drives req_ready[g]=1 combinationally in the same cycle. On that edge, latch the job, set rr_ptr=g and go to CRST.
  - req_ready is never asserted outside IDLE.
- CRST:
  - core_rst=1 for exactly RST_CYCLES cycles, then go to RUN with cnt cleared.
- RUN:
  - core_rst=0 and core_start=1 throughout.
  - cnt increments every cycle.
  - core_ready is ignored in the first RUN cycle, to discard stale ready.
  - From the second RUN cycle on, core_ready=1 captures core_result and core_tag, computes rsp_tag_ok and goes to RESP; rsp_valid rises the next cycle.
  - Timeout: if cnt reaches TIMEOUT_CYCLES-1 without core_ready, go to RESP with rsp_timeout=1, rsp_data=0, rsp_tag=0, rsp_tag_ok=0.
  - If core_ready and timeout occur in the same cycle, core_ready wins.
- RESP:
  - core_rst=1, core_start=0.
  - rsp_valid=1; all rsp_* fields stay stable until the rsp_ready handshake.
  - On handshake, rsp_valid drops the next cycle and the FSM returns to IDLE.
  - IDLE may grant a new job in the cycle right after the handshake.
- Requester rules:
  - A requester must hold req_valid and its fields stable until req_ready.
  - req_valid dropping before grant is legal and no job is taken.
- Latency: acceptance at edge T.
  - core_start rises at T+RST_CYCLES.
  - Earliest rsp_valid is at T+RST_CYCLES+2.
- rsp_tag_ok is a full 128-bit equality compare; it is forced to 1 for encrypt jobs.

Test Plan:
1. Single encrypt on req0 (key 00112233445566778899AABBCCDDEEFF, IV 0123456789ABCDEF0123456789ABCDEF, data AABBCCDDEEFF00112233445566778899); core model asserts ready 5 cycles after start → req_ready=01 for one cycle; core_rst high for 2 cycles; rsp_id=0, rsp_data/rsp_tag equal the model outputs, rsp_tag_ok=1, rsp_timeout=0.
2. Both requesters valid continuously, rsp_ready tied to 1 → grants alternate 0,1,0,1; no requester is granted twice in a row while the other waits.
3. Decrypt on req1 with matching expected tag → rsp_tag_ok=1. Repeat with one tag bit flipped → rsp_tag_ok=0, rsp_data unchanged.
4. Core never asserts ready, TIMEOUT_CYCLES=16 → rsp_timeout=1 exactly 16 RUN cycles after start; rsp_data=0, rsp_tag=0; the FSM returns to IDLE after the handshake.
5. rsp_ready held low for 10 cycles while a new req0 is pending → rsp fields stable, req_ready=00 throughout; req0 is granted the cycle after the handshake.
6. rst pulled low during RUN → same-cycle async clear: core_rst=1, core_start=0, busy=0, rsp_valid=0. After release, req0 wins the first grant.

Source files
------------

// File: rtl/acorn128_job_sched.sv
// Round-robin job scheduler sharing one acorn128 core between two requesters.
// Holds the core in reset, runs one job under a timeout, and returns the result on a valid/ready channel.
module acorn128_job_sched #(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_encrypt,
    input  logic [255:0]   req_key,
    input  logic [255:0]   req_iv,
    input  logic [255:0]   req_data,
    input  logic [255:0]   req_ad,
    input  logic [127:0]   req_len,
    input  logic [255:0]   req_tag,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [127:0]   rsp_data,
    output logic [127:0]   rsp_tag,
    output logic           rsp_tag_ok,
    output logic           rsp_timeout,
    output logic           busy,
    output logic           core_rst,
    output logic           core_start,
    output logic           core_encrypt,
    output logic [127:0]   core_key,
    output logic [127:0]   core_iv,
    output logic [127:0]   core_plaintext,
    output logic [127:0]   core_ciphertext,
    output logic [127:0]   core_ad,
    output logic [63:0]    core_len,
    input  logic [127:0]   core_result,
    input  logic [127:0]   core_tag,
    input  logic           core_ready
);

    typedef enum logic [1:0] {IDLE, CRST, RUN, RESP} state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               enc_q, enc_d;
    logic [127:0]       key_q, key_d, iv_q, iv_d, data_q, data_d, ad_q, ad_d, exp_tag_q, exp_tag_d;
    logic [63:0]        len_q, len_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [127:0]       rsp_data_q, rsp_data_d, rsp_tag_q, rsp_tag_d;
    logic               rsp_ok_q, rsp_ok_d, rsp_to_q, rsp_to_d;
    logic               gnt_any, gnt_idx;

    // Both pending: the requester not served last wins.
    always_comb begin
        gnt_any = |req_valid;
        gnt_idx = (req_valid == 2'b11) ? ~rr_ptr_q : req_valid[1];
    end

    assign req_ready = (state_q == IDLE && gnt_any && rst) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        enc_d       = enc_q;
        key_d       = key_q;
        iv_d        = iv_q;
        data_d      = data_q;
        ad_d        = ad_q;
        exp_tag_d   = exp_tag_q;
        len_d       = len_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    enc_d     = req_encrypt[gnt_idx];
                    key_d     = gnt_idx ? req_key[255:128]  : req_key[127:0];
                    iv_d      = gnt_idx ? req_iv[255:128]   : req_iv[127:0];
                    data_d    = gnt_idx ? req_data[255:128] : req_data[127:0];
                    ad_d      = gnt_idx ? req_ad[255:128]   : req_ad[127:0];
                    exp_tag_d = gnt_idx ? req_tag[255:128]  : req_tag[127:0];
                    len_d     = gnt_idx ? req_len[127:64]   : req_len[63:0];
                    rr_ptr_d  = gnt_idx;
                    cnt_d     = '0;
                    state_d   = CRST;
                end
            end
            CRST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // First RUN cycle may still see ready left over from the previous job.
                if (core_ready && cnt_q != '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = rr_ptr_q;
                    rsp_data_d  = core_result;
                    rsp_tag_d   = core_tag;
                    rsp_ok_d    = enc_q | (core_tag == exp_tag_q);
                    rsp_to_d    = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = rr_ptr_q;
                    rsp_data_d  = '0;
                    rsp_tag_d   = '0;
                    rsp_ok_d    = 1'b0;
                    rsp_to_d    = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = 1'b0;
                    rsp_data_d  = '0;
                    rsp_tag_d   = '0;
                    rsp_ok_d    = 1'b0;
                    rsp_to_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b1;
            cnt_q       <= '0;
            enc_q       <= 1'b0;
            key_q       <= '0;
            iv_q        <= '0;
            data_q      <= '0;
            ad_q        <= '0;
            exp_tag_q   <= '0;
            len_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            enc_q       <= enc_d;
            key_q       <= key_d;
            iv_q        <= iv_d;
            data_q      <= data_d;
            ad_q        <= ad_d;
            exp_tag_q   <= exp_tag_d;
            len_q       <= len_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = rsp_id_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_tag         = rsp_tag_q;
    assign rsp_tag_ok      = rsp_ok_q;
    assign rsp_timeout     = rsp_to_q;
    assign busy            = (state_q != IDLE);
    assign core_rst        = (state_q != RUN);
    assign core_start      = (state_q == RUN);
    assign core_encrypt    = enc_q;
    assign core_key        = key_q;
    assign core_iv         = iv_q;
    assign core_plaintext  = data_q;
    assign core_ciphertext = data_q;
    assign core_ad         = ad_q;
    assign core_len        = len_q;

endmodule

// File: tb/tb_acorn128_job_sched.sv
// Bench for acorn128_job_sched: behavioural core stand-in plus per-scenario checks
// against expectations derived from the scheduler's arbitration and timing rules.
module tb_acorn128_job_sched;

    localparam int RST_C = 2;
    localparam int TO_C  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid, req_ready, req_encrypt;
    logic [255:0]   req_key, req_iv, req_data, req_ad, req_tag;
    logic [127:0]   req_len;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_tag_ok, rsp_timeout, busy;
    logic [127:0]   rsp_data, rsp_tag;
    logic           core_rst, core_start, core_encrypt;
    logic [127:0]   core_key, core_iv, core_plaintext, core_ciphertext, core_ad;
    logic [63:0]    core_len;
    logic [127:0]   core_result = '0, core_tag = '0;
    logic           core_ready = 1'b0;

    int checks = 0, errors = 0, cyc = 0, last_grant = 1;
    int core_delay = 5, core_k = 0;
    bit core_stale = 0;

    logic [1:0]   obs_grant, obs_rdy2;
    logic         obs_crst, obs_valid, obs_id, obs_ok, obs_to, obs_v_after, obs_busy_after;
    logic [127:0] obs_data, obs_tag;
    int           obs_acc, obs_start, obs_rsp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    acorn128_job_sched #(.RST_CYCLES(RST_C), .TIMEOUT_CYCLES(TO_C), .CNT_W(13)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_encrypt(req_encrypt), .req_key(req_key), .req_iv(req_iv), .req_data(req_data),
        .req_ad(req_ad), .req_len(req_len), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_tag_ok(rsp_tag_ok), .rsp_timeout(rsp_timeout), .busy(busy),
        .core_rst(core_rst), .core_start(core_start), .core_encrypt(core_encrypt),
        .core_key(core_key), .core_iv(core_iv), .core_plaintext(core_plaintext),
        .core_ciphertext(core_ciphertext), .core_ad(core_ad), .core_len(core_len),
        .core_result(core_result), .core_tag(core_tag), .core_ready(core_ready)
    );

    function automatic logic [127:0] f_res(input logic enc, input logic [127:0] k, v, d, a, input logic [63:0] l);
        return d ^ k ^ {v[63:0], v[127:64]} ^ {a[0], a[127:1]} ^ {l, ~l} ^
               (enc ? 128'h0 : {64'hFFFF0000FFFF0000, 64'h0});
    endfunction

    function automatic logic [127:0] f_tag(input logic enc, input logic [127:0] k, v, d, a, input logic [63:0] l);
        return k + {v[95:0], v[127:96]} + (a ^ {l, l}) + d + (enc ? 128'd1 : 128'd7);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core stand-in: ready appears core_delay cycles after start; optional stale ready beforehand.
    always @(negedge clk) begin
        if (core_rst) begin
            core_k      = 0;
            core_ready  = core_stale;
            core_result = {4{32'hDEADBEEF}};
            core_tag    = {4{32'hBAD0BAD0}};
        end else begin
            core_k++;
            if (core_k == 1 && core_stale) begin
                core_ready  = 1'b1;
                core_result = {4{32'hDEADBEEF}};
                core_tag    = {4{32'hBAD0BAD0}};
            end else if (core_k >= core_delay) begin
                core_ready  = 1'b1;
                core_result = f_res(core_encrypt, core_key, core_iv,
                                    core_encrypt ? core_plaintext : core_ciphertext, core_ad, core_len);
                core_tag    = f_tag(core_encrypt, core_key, core_iv,
                                    core_encrypt ? core_plaintext : core_ciphertext, core_ad, core_len);
            end else begin
                core_ready  = 1'b0;
                core_result = '0;
                core_tag    = '0;
            end
        end
    end

    task automatic set_fields(input int r, input logic enc, input logic [127:0] k, v, d, a,
                              input logic [63:0] l, input logic [127:0] t);
        req_encrypt[r]         = enc;
        req_key[r*128 +: 128]  = k;
        req_iv[r*128 +: 128]   = v;
        req_data[r*128 +: 128] = d;
        req_ad[r*128 +: 128]   = a;
        req_len[r*64 +: 64]    = l;
        req_tag[r*128 +: 128]  = t;
    endtask

    // Single-requester job: drive, wait grant, wait start, wait response, handshake.
    task automatic do_job(input int r, input logic enc, input logic [127:0] k, v, d, a,
                          input logic [63:0] l, input logic [127:0] t);
        int n;
        @(negedge clk);
        set_fields(r, enc, k, v, d, a, l, t);
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        obs_grant = req_ready;
        obs_acc   = cyc + 1;
        @(negedge clk);
        obs_rdy2  = req_ready;
        obs_crst  = core_rst;
        req_valid[r] = 1'b0;
        n = 0;
        while (!core_start && n < 50) begin @(negedge clk); n++; end
        obs_start = cyc;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        obs_rsp   = cyc;
        obs_valid = rsp_valid;
        obs_id    = rsp_id;
        obs_data  = rsp_data;
        obs_tag   = rsp_tag;
        obs_ok    = rsp_tag_ok;
        obs_to    = rsp_timeout;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        obs_v_after    = rsp_valid;
        obs_busy_after = busy;
        last_grant = r;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req_encrypt = '0; req_key = '0; req_iv = '0; req_data = '0; req_ad = '0; req_len = '0; req_tag = '0;
        #3;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_timeout !== 1'b0) begin errors++;
            $display("FAIL rst_rsp got v=%b d=%h to=%b exp 0", rsp_valid, rsp_data, rsp_timeout); end
        checks++; if (busy !== 1'b0 || core_rst !== 1'b1 || core_start !== 1'b0) begin errors++;
            $display("FAIL rst_ctrl got busy=%b crst=%b start=%b exp 0 1 0", busy, core_rst, core_start); end
        checks++; if (core_key !== '0 || core_len !== '0 || core_plaintext !== '0) begin errors++;
            $display("FAIL rst_core_data got key=%h exp 0", core_key); end
        req_valid = 2'b00;
        @(negedge clk); rst = 1'b1;
        last_grant = 1;
    endtask

    task automatic test_single_encrypt();
        logic [127:0] k, v, d, a;
        k = 128'h00112233445566778899AABBCCDDEEFF;
        v = 128'h0123456789ABCDEF0123456789ABCDEF;
        d = 128'hAABBCCDDEEFF00112233445566778899;
        a = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        core_delay = 5; core_stale = 0;
        do_job(0, 1'b1, k, v, d, a, 64'd16, '0);
        checks++; if (obs_grant !== 2'b01) begin errors++; $display("FAIL enc_grant got %b exp 01", obs_grant); end
        checks++; if (obs_rdy2 !== 2'b00 || obs_crst !== 1'b1) begin errors++;
            $display("FAIL enc_after_grant got ready=%b crst=%b exp 00 1", obs_rdy2, obs_crst); end
        checks++; if (obs_start - obs_acc !== RST_C) begin errors++;
            $display("FAIL enc_start_lat got %0d exp %0d", obs_start - obs_acc, RST_C); end
        checks++; if (obs_rsp - obs_start !== 5) begin errors++;
            $display("FAIL enc_rsp_lat got %0d exp 5", obs_rsp - obs_start); end
        checks++; if (obs_valid !== 1'b1 || obs_id !== 1'b0 || obs_to !== 1'b0 || obs_ok !== 1'b1) begin errors++;
            $display("FAIL enc_flags got v=%b id=%b to=%b ok=%b exp 1 0 0 1", obs_valid, obs_id, obs_to, obs_ok); end
        checks++; if (obs_data !== f_res(1'b1, k, v, d, a, 64'd16) || obs_tag !== f_tag(1'b1, k, v, d, a, 64'd16)) begin errors++;
            $display("FAIL enc_result got %h/%h exp %h/%h", obs_data, obs_tag,
                     f_res(1'b1, k, v, d, a, 64'd16), f_tag(1'b1, k, v, d, a, 64'd16)); end
        checks++; if (obs_v_after !== 1'b0 || obs_busy_after !== 1'b0) begin errors++;
            $display("FAIL enc_after_hs got v=%b busy=%b exp 0 0", obs_v_after, obs_busy_after); end
    endtask

    task automatic test_round_robin();
        logic [127:0] k[2], v[2], d[2], a[2];
        logic [63:0]  l[2];
        int q[$];
        int expg, grants, resps, n;
        for (int i = 0; i < 2; i++) begin
            k[i] = rnd128(); v[i] = rnd128(); d[i] = rnd128(); a[i] = rnd128(); l[i] = {$urandom(), $urandom()};
        end
        core_delay = 3; core_stale = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) set_fields(i, 1'b1, k[i], v[i], d[i], a[i], l[i], '0);
        rsp_ready = 1'b1; req_valid = 2'b11;
        expg = 1 - last_grant; grants = 0; resps = 0; n = 0;
        while ((resps < 4 || q.size() > 0) && n < 300) begin
            if (resps >= 4) req_valid = 2'b00;
            #1;
            if (req_ready !== 2'b00) begin
                checks++; if (req_ready !== (expg ? 2'b10 : 2'b01)) begin errors++;
                    $display("FAIL rr_grant%0d got %b exp %0d", grants, req_ready, expg); end
                q.push_back(expg); last_grant = expg; expg = 1 - expg; grants++;
            end
            if (rsp_valid === 1'b1 && q.size() > 0) begin
                int id;
                id = q.pop_front();
                checks++; if (rsp_id !== id[0] || rsp_data !== f_res(1'b1, k[id], v[id], d[id], a[id], l[id])) begin errors++;
                    $display("FAIL rr_rsp%0d got id=%b d=%h exp id=%0d", resps, rsp_id, rsp_data, id); end
                resps++;
            end
            @(negedge clk); n++;
        end
        req_valid = 2'b00; rsp_ready = 1'b0;
        checks++; if (resps < 4 || q.size() != 0) begin errors++;
            $display("FAIL rr_done got resps=%0d pending=%0d exp >=4 0", resps, q.size()); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_decrypt_tag();
        logic [127:0] k, v, d, a, t, first;
        logic [63:0]  l;
        k = rnd128(); v = rnd128(); d = rnd128(); a = rnd128(); l = 64'd9;
        t = f_tag(1'b0, k, v, d, a, l);
        core_delay = 3; core_stale = 1;
        do_job(1, 1'b0, k, v, d, a, l, t);
        first = obs_data;
        checks++; if (obs_grant !== 2'b10 || obs_id !== 1'b1) begin errors++;
            $display("FAIL dec_grant got %b id=%b exp 10 1", obs_grant, obs_id); end
        checks++; if (obs_ok !== 1'b1 || obs_to !== 1'b0 || obs_data !== f_res(1'b0, k, v, d, a, l)) begin errors++;
            $display("FAIL dec_match got ok=%b to=%b d=%h exp 1 0 %h", obs_ok, obs_to, obs_data, f_res(1'b0, k, v, d, a, l)); end
        checks++; if (obs_rsp - obs_start !== 3) begin errors++;
            $display("FAIL dec_stale_lat got %0d exp 3", obs_rsp - obs_start); end
        do_job(1, 1'b0, k, v, d, a, l, t ^ (128'd1 << 37));
        checks++; if (obs_ok !== 1'b0 || obs_data !== first) begin errors++;
            $display("FAIL dec_mismatch got ok=%b d=%h exp 0 %h", obs_ok, obs_data, first); end
        core_stale = 0;
    endtask

    task automatic test_timeout();
        logic [127:0] k, v, d, a;
        k = rnd128(); v = rnd128(); d = rnd128(); a = rnd128();
        core_delay = 1000; core_stale = 0;
        do_job(0, 1'b1, k, v, d, a, 64'd3, '0);
        checks++; if (obs_to !== 1'b1 || obs_data !== '0 || obs_tag !== '0 || obs_ok !== 1'b0) begin errors++;
            $display("FAIL to_fields got to=%b d=%h t=%h ok=%b exp 1 0 0 0", obs_to, obs_data, obs_tag, obs_ok); end
        checks++; if (obs_rsp - obs_start !== TO_C) begin errors++;
            $display("FAIL to_lat got %0d exp %0d", obs_rsp - obs_start, TO_C); end
        checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL to_idle got busy=%b exp 0", obs_busy_after); end
        core_delay = TO_C;
        do_job(1, 1'b1, k, v, d, a, 64'd3, '0);
        checks++; if (obs_to !== 1'b0 || obs_data !== f_res(1'b1, k, v, d, a, 64'd3) || obs_rsp - obs_start !== TO_C) begin errors++;
            $display("FAIL to_ready_wins got to=%b lat=%0d exp 0 %0d", obs_to, obs_rsp - obs_start, TO_C); end
        core_delay = TO_C + 1;
        do_job(0, 1'b1, k, v, d, a, 64'd3, '0);
        checks++; if (obs_to !== 1'b1 || obs_rsp - obs_start !== TO_C) begin errors++;
            $display("FAIL to_edge got to=%b lat=%0d exp 1 %0d", obs_to, obs_rsp - obs_start, TO_C); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k, v, d, a, sd, st;
        logic bad;
        int n;
        k = rnd128(); v = rnd128(); d = rnd128(); a = rnd128();
        core_delay = 4; core_stale = 0;
        @(negedge clk);
        set_fields(1, 1'b1, k, v, d, a, 64'd5, '0);
        req_valid = 2'b10; #1;
        n = 0; while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk); req_valid = 2'b00;
        n = 0; while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        sd = rsp_data; st = rsp_tag;
        set_fields(0, 1'b1, d, a, k, v, 64'd7, '0);
        req_valid = 2'b01;
        bad = (rsp_valid !== 1'b1);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== sd || rsp_tag !== st) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_stable got ready=%b v=%b d=%h exp 00 1 %h", req_ready, rsp_valid, rsp_data, sd); end
        checks++; if (sd !== f_res(1'b1, k, v, d, a, 64'd5)) begin errors++; $display("FAIL bp_data got %h", sd); end
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_regrant got %b exp 01", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        n = 0; while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== f_res(1'b1, d, a, k, v, 64'd7)) begin errors++;
            $display("FAIL bp_second got v=%b id=%b d=%h", rsp_valid, rsp_id, rsp_data); end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        last_grant = 0;
    endtask

    task automatic test_reset_mid_job();
        logic bad;
        int n;
        core_delay = 1000; core_stale = 0;
        @(negedge clk);
        set_fields(1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), 64'd1, '0);
        req_valid = 2'b10; #1;
        n = 0; while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk); req_valid = 2'b00;
        n = 0; while (!core_start && n < 50) begin @(negedge clk); n++; end
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL rm_run got start=%b exp 1", core_start); end
        @(negedge clk); #2; rst = 1'b0; #1;
        checks++; if (core_rst !== 1'b1 || core_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || core_key !== '0) begin errors++;
            $display("FAIL rm_clear got crst=%b start=%b busy=%b v=%b exp 1 0 0 0", core_rst, core_start, busy, rsp_valid); end
        @(negedge clk); rst = 1'b1; last_grant = 1;
        core_delay = 4;
        bad = 1'b0;
        repeat (3) begin @(negedge clk); #1; if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1; end
        checks++; if (bad) begin errors++; $display("FAIL rm_dropped got v=%b busy=%b exp 0 0", rsp_valid, busy); end
        @(negedge clk);
        set_fields(0, 1'b1, 128'h1, 128'h2, 128'h3, 128'h4, 64'd2, '0);
        req_valid = 2'b11; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant got %b exp 01", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        n = 0; while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL rm_rsp got v=%b id=%b exp 1 0", rsp_valid, rsp_id); end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        last_grant = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int r, lat;
            logic enc, exp_to, exp_ok;
            logic [127:0] k, v, d, a, t, er, et;
            logic [63:0] l;
            r = $urandom_range(0, 1); enc = 1'($urandom_range(0, 1));
            k = rnd128(); v = rnd128(); d = rnd128(); a = rnd128(); l = {$urandom(), $urandom()};
            t = (!enc && $urandom_range(0, 1) == 1) ? f_tag(enc, k, v, d, a, l) : rnd128();
            core_delay = $urandom_range(1, 20); core_stale = 1'($urandom_range(0, 1));
            exp_to = (core_delay > TO_C);
            lat    = exp_to ? TO_C : (core_delay < 2 ? 2 : core_delay);
            er     = exp_to ? '0 : f_res(enc, k, v, d, a, l);
            et     = exp_to ? '0 : f_tag(enc, k, v, d, a, l);
            exp_ok = exp_to ? 1'b0 : (enc ? 1'b1 : (et == t));
            do_job(r, enc, k, v, d, a, l, t);
            checks++; if (obs_grant !== (r ? 2'b10 : 2'b01) || obs_id !== r[0] || obs_valid !== 1'b1) begin errors++;
                $display("FAIL rnd%0d_id got g=%b id=%b v=%b exp r=%0d", i, obs_grant, obs_id, obs_valid, r); end
            checks++; if (obs_data !== er || obs_tag !== et) begin errors++;
                $display("FAIL rnd%0d_data got %h/%h exp %h/%h", i, obs_data, obs_tag, er, et); end
            checks++; if (obs_ok !== exp_ok || obs_to !== exp_to) begin errors++;
                $display("FAIL rnd%0d_flags got ok=%b to=%b exp %b %b", i, obs_ok, obs_to, exp_ok, exp_to); end
            checks++; if (obs_rsp - obs_start !== lat || obs_start - obs_acc !== RST_C) begin errors++;
                $display("FAIL rnd%0d_lat got %0d/%0d exp %0d/%0d", i, obs_rsp - obs_start, obs_start - obs_acc, lat, RST_C); end
        end
        core_stale = 0;
    endtask

    initial begin
        test_reset();
        test_single_encrypt();
        test_round_robin();
        test_decrypt_tag();
        test_timeout();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got time limit exp finish");
        $fatal(1, "watchdog");
    end

endmodule
